key_event_reader: RTL and testbench

- CPU-side reader for the keypad/digital-input front end.
- Consumes the front end's level interrupt and key code, and turns each press into a key event.
- Adds optional auto-repeat while a key is held.
- Queues events in a 4-deep FIFO, raises a CPU interrupt while events are pending, and exposes data/status registers on a simple read-strobe bus.

---
 rtl/key_evt_pkg.sv | 21 ++
 rtl/key_evt_fifo.sv | 63 ++++++
 rtl/key_event_reader.sv | 169 ++++++++++++++++
 tb/tb_key_event_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key event reader: press FSM states,
// bus register addresses and STATUS bit positions.
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2,
    REPEAT = 2'd3
  } state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STS_OVF     = 7;
  localparam int STS_FULL    = 6;
  localparam int STS_EMPTY   = 5;
  localparam int STS_CNT_MSB = 2;
  localparam int STS_CNT_LSB = 0;

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO holding key codes. The head entry is visible on
// dout without a read cycle so a bus read can return and pop it in one edge.
module key_evt_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees the slot this edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/key_event_reader.sv
// CPU-side key event reader: synchronises the front-end interrupt, turns
// presses (plus auto-repeat) into queued events and serves DATA/STATUS reads.
module key_event_reader
  import key_evt_pkg::*;
#(
  parameter int CODE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 2,
  parameter int REP_DELAY  = 20000000,
  parameter int REP_RATE   = 5000000,
  parameter int CNT_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_irq,
  input  logic              cs,
  input  logic              rd,
  input  logic              addr,
  output logic [7:0]        rdata,
  output logic              irq_cpu
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REP_RATE - 1);

  logic              sync1_q, irq_s_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ev_push;
  logic [CODE_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              rd_data, rd_status, pop_ok, push_ok, overflow, empty_next;
  logic              ovf_q, ovf_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              irq_q;
  logic [2:0]        cnt3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) {irq_s_q, sync1_q} <= 2'b00;
    else       {irq_s_q, sync1_q} <= {sync1_q, key_irq};
  end

  // Release (irq_s low) is checked first in every state so it beats a push.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_s_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!irq_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          ev_push = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!irq_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REP_DELAY != 0) begin
          if (cnt_q == DELAY_LAST) begin
            ev_push = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!irq_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          ev_push = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  key_evt_fifo #(
    .DW    (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_push),
    .pop   (rd_data),
    .din   (key_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_data   = cs & rd & (addr == ADDR_DATA);
  assign rd_status = cs & rd & (addr == ADDR_STATUS);
  assign pop_ok    = rd_data & ~fifo_empty;
  assign push_ok   = ev_push & (~fifo_full | pop_ok);
  assign overflow  = ev_push & fifo_full & ~pop_ok;
  assign empty_next = (fifo_empty & ~push_ok) |
                      ((fifo_count == CW'(1)) & pop_ok & ~push_ok);
  assign cnt3 = 3'(fifo_count);

  always_comb begin
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (rd_status) ovf_d = 1'b0;
    if (overflow)  ovf_d = 1'b1;
    if (rd_data) begin
      rdata_d = fifo_empty ? 8'h00 : 8'(fifo_dout);
    end else if (rd_status) begin
      rdata_d                          = 8'h00;
      rdata_d[STS_OVF]                 = ovf_q;
      rdata_d[STS_FULL]                = fifo_full;
      rdata_d[STS_EMPTY]               = fifo_empty;
      rdata_d[STS_CNT_MSB:STS_CNT_LSB] = cnt3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      irq_q   <= ~empty_next;
    end
  end

  assign rdata   = rdata_q;
  assign irq_cpu = irq_q;

endmodule

// File: tb/tb_key_event_reader.sv
// Scoreboard bench for key_event_reader: stimulus queues expected bus and irq
// values, a monitor after each rising edge pops and compares them.
module tb_key_event_reader;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_irq;
  logic       cs, rd, addr;
  logic [7:0] rdata;
  logic       irq_cpu;

  key_event_reader #(
    .CODE_W     (4),
    .FIFO_DEPTH (4),
    .SETTLE_CYC (2),
    .REP_DELAY  (20),
    .REP_RATE   (8),
    .CNT_W      (25)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .key_irq  (key_irq),
    .cs       (cs),
    .rd       (rd),
    .addr     (addr),
    .rdata    (rdata),
    .irq_cpu  (irq_cpu)
  );

  always #5 clk = ~clk;

  logic [7:0] rd_val_q[$];
  string      rd_name_q[$];
  bit         chk_kind_q[$];   // 0 = irq_cpu, 1 = rdata
  logic [7:0] chk_val_q[$];
  string      chk_name_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;
  bit   done = 1'b0;
  logic mon_acc;
  logic [7:0] mon_exp;
  string mon_name;
  bit   mon_kind;

  always @(posedge clk) begin
    mon_acc = cs & rd & ~reset;
    #1;
    cycles++;
    if (mon_acc) begin
      checks++;
      if (rd_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: rdata=%02h, required no access", rdata);
      end else begin
        mon_exp  = rd_val_q.pop_front();
        mon_name = rd_name_q.pop_front();
        if (rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s: rdata=%02h required %02h", mon_name, rdata, mon_exp);
        end else begin
          $display("ok   %s: rdata=%02h", mon_name, rdata);
        end
      end
    end
    while (chk_kind_q.size() != 0) begin
      mon_kind = chk_kind_q.pop_front();
      mon_exp  = chk_val_q.pop_front();
      mon_name = chk_name_q.pop_front();
      checks++;
      if (mon_kind == 1'b0) begin
        if (irq_cpu !== mon_exp[0]) begin
          errors++;
          $display("FAIL %s: irq_cpu=%b required %b", mon_name, irq_cpu, mon_exp[0]);
        end else begin
          $display("ok   %s: irq_cpu=%b", mon_name, irq_cpu);
        end
      end else begin
        if (rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s: rdata=%02h required %02h", mon_name, rdata, mon_exp);
        end else begin
          $display("ok   %s: rdata=%02h", mon_name, rdata);
        end
      end
    end
    if (done || cycles > 5000) begin
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL watchdog: cycles=%0d required <= 5000", cycles);
      end
      checks++;
      if (rd_val_q.size() != 0) begin
        errors++;
        $display("FAIL pending_reads: left=%0d required 0", rd_val_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one bus access on the next rising edge; returns at the following negedge.
  task automatic rd_reg(input logic a, input logic [7:0] e, input string n);
    cs = 1'b1; rd = 1'b1; addr = a;
    rd_val_q.push_back(e);
    rd_name_q.push_back(n);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  // Value expected just after the next rising edge.
  task automatic expect_after(input bit k, input logic [7:0] v, input string n);
    chk_kind_q.push_back(k);
    chk_val_q.push_back(v);
    chk_name_q.push_back(n);
  endtask

  initial begin
    reset = 1'b1; key_irq = 1'b0; key_code = 4'h0;
    cs = 1'b0; rd = 1'b0; addr = 1'b0;
    cyc(2);
    expect_after(1'b0, 8'h00, "reset_irq");
    expect_after(1'b1, 8'h00, "reset_rdata");
    cyc(1);
    reset = 1'b0;
    cyc(1);
    rd_reg(1'b1, 8'h20, "reset_status");

    // single press
    key_code = 4'h5; key_irq = 1'b1;
    cyc(10);
    key_irq = 1'b0;
    cyc(5);
    expect_after(1'b0, 8'h01, "press_irq_high");
    cyc(1);
    rd_reg(1'b0, 8'h05, "press_data");
    expect_after(1'b0, 8'h00, "press_irq_low");
    rd_reg(1'b1, 8'h20, "press_status");

    // glitch rejected
    key_code = 4'h6; key_irq = 1'b1;
    cyc(2);
    key_irq = 1'b0;
    cyc(6);
    expect_after(1'b0, 8'h00, "glitch_irq");
    cyc(1);
    rd_reg(1'b1, 8'h20, "glitch_status");

    // auto-repeat: pushes at first push (+5), +20, +28, +36
    key_code = 4'h9; key_irq = 1'b1;
    cyc(24);
    rd_reg(1'b1, 8'h01, "rep_before_delay");
    rd_reg(1'b1, 8'h02, "rep_after_delay");
    cyc(18);
    key_irq = 1'b0;
    cyc(6);
    rd_reg(1'b1, 8'h44, "rep_status");
    for (int i = 0; i < 4; i++) rd_reg(1'b0, 8'h09, "rep_data");
    rd_reg(1'b1, 8'h20, "rep_drained");

    // overflow: six pushes with codes 1..6, only 1..4 kept
    key_code = 4'h1; key_irq = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      case (i)
        5:  key_code = 4'h2;
        25: key_code = 4'h3;
        33: key_code = 4'h4;
        41: key_code = 4'h5;
        49: key_code = 4'h6;
        default: ;
      endcase
    end
    key_irq = 1'b0;
    cyc(6);
    rd_reg(1'b1, 8'hC4, "ovf_status");
    rd_reg(1'b1, 8'h44, "ovf_cleared");
    rd_reg(1'b0, 8'h01, "ovf_data0");
    rd_reg(1'b0, 8'h02, "ovf_data1");
    rd_reg(1'b0, 8'h03, "ovf_data2");
    rd_reg(1'b0, 8'h04, "ovf_data3");
    rd_reg(1'b0, 8'h00, "ovf_empty_data");
    rd_reg(1'b1, 8'h20, "ovf_no_underflow");

    // push and DATA read together while full
    key_code = 4'hA; key_irq = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      cyc(1);
      case (i)
        5:  key_code = 4'hB;
        25: key_code = 4'hC;
        33: key_code = 4'hD;
        41: key_code = 4'hE;
        default: ;
      endcase
    end
    rd_reg(1'b0, 8'h0A, "simul_head");
    key_irq = 1'b0;
    cyc(6);
    rd_reg(1'b1, 8'h44, "simul_status");
    rd_reg(1'b0, 8'h0B, "simul_data1");
    rd_reg(1'b0, 8'h0C, "simul_data2");
    rd_reg(1'b0, 8'h0D, "simul_data3");
    rd_reg(1'b0, 8'h0E, "simul_data4");
    rd_reg(1'b1, 8'h20, "simul_drained");

    // reset while in REPEAT with two entries queued
    key_code = 4'h7; key_irq = 1'b1;
    cyc(26);
    rd_reg(1'b1, 8'h02, "rst_pre_status");
    cyc(3);
    #2;
    reset = 1'b1; key_irq = 1'b0;
    expect_after(1'b0, 8'h00, "rst_irq");
    expect_after(1'b1, 8'h00, "rst_rdata");
    cyc(3);
    reset = 1'b0;
    cyc(30);
    expect_after(1'b0, 8'h00, "rst_after_irq");
    cyc(1);
    rd_reg(1'b1, 8'h20, "rst_after_status");

    cyc(2);
    done = 1'b1;
    cyc(5);
  end

endmodule
